// File: rtl/serial_word_tx_pkg.sv
// rtl/serial_word_tx_pkg.sv - shared state encodings and line levels for the serial word link
package serial_word_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/serial_word_tx_bit_timer.sv
// rtl/serial_word_tx_bit_timer.sv - per-bit clock divider with clear and bit_end tick
module serial_word_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_end
);

  // Keep at least one counter bit so CLKS_PER_BIT=1 still elaborates
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign bit_end = !clear && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/serial_word_tx.sv
// rtl/serial_word_tx.sv - framed parallel-to-serial word transmitter (start, data, stop)
module serial_word_tx
  import serial_word_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int CLKS_PER_BIT = 4,
  parameter bit LSB_FIRST    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  tx_out,
  output logic                  tx_busy,
  output logic                  done
);

  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] sreg, sreg_shifted;
  logic [BW-1:0]         bit_cnt, bit_cnt_next;
  logic                  tx_next, done_next, load, shift;
  logic                  first_cur, first_shifted;
  logic                  bit_end;

  serial_word_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state == ST_IDLE),
    .bit_end(bit_end)
  );

  assign in_ready = (state == ST_IDLE);
  assign tx_busy  = (state != ST_IDLE);

  assign sreg_shifted  = LSB_FIRST ? {1'b0, sreg[DATA_WIDTH-1:1]} : {sreg[DATA_WIDTH-2:0], 1'b0};
  assign first_cur     = LSB_FIRST ? sreg[0] : sreg[DATA_WIDTH-1];
  assign first_shifted = LSB_FIRST ? sreg_shifted[0] : sreg_shifted[DATA_WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // tx_out is registered, so each bit-boundary decision loads the level of the next bit
  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    tx_next      = tx_out;
    done_next    = 1'b0;
    load         = 1'b0;
    shift        = 1'b0;
    case (state)
      ST_IDLE: begin
        tx_next = IDLE_LEVEL;
        if (in_valid) begin
          state_next = ST_START;
          load       = 1'b1;
          tx_next    = START_LEVEL;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_next = ST_DATA;
          tx_next    = first_cur;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift = 1'b1;
          if (bit_cnt == LAST_BIT) begin
            state_next   = ST_STOP;
            bit_cnt_next = '0;
            tx_next      = IDLE_LEVEL;
          end else begin
            bit_cnt_next = bit_cnt + BW'(1);
            tx_next      = first_shifted;
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg    <= '0;
      bit_cnt <= '0;
      tx_out  <= IDLE_LEVEL;
      done    <= 1'b0;
    end else begin
      if (load) begin
        sreg <= in_data;
      end else if (shift) begin
        sreg <= sreg_shifted;
      end
      bit_cnt <= bit_cnt_next;
      tx_out  <= tx_next;
      done    <= done_next;
    end
  end

endmodule

// File: tb/tb_serial_word_tx.sv
// tb/tb_serial_word_tx.sv - self-checking bench for serial_word_tx
module tb_serial_word_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid [3];
  logic [15:0] in_data  [3];
  logic        in_ready [3];
  logic        tx       [3];
  logic        busy     [3];
  logic        done     [3];

  int cpb_u [3] = '{4, 4, 1};
  bit lsb_u [3] = '{1'b1, 1'b0, 1'b1};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_word_tx #(.DATA_WIDTH(16), .CLKS_PER_BIT(4), .LSB_FIRST(1'b1)) dut_lsb4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .tx_out(tx[0]), .tx_busy(busy[0]), .done(done[0]));

  serial_word_tx #(.DATA_WIDTH(16), .CLKS_PER_BIT(4), .LSB_FIRST(1'b0)) dut_msb4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .tx_out(tx[1]), .tx_busy(busy[1]), .done(done[1]));

  serial_word_tx #(.DATA_WIDTH(16), .CLKS_PER_BIT(1), .LSB_FIRST(1'b1)) dut_lsb1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .tx_out(tx[2]), .tx_busy(busy[2]), .done(done[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Transmission order of a word: bit 15 of the result goes on the line first
  function automatic logic [15:0] tx_order(input logic [15:0] w, input bit lsb);
    logic [15:0] r;
    r = w;
    if (lsb) for (int i = 0; i < 16; i++) r[15-i] = w[i];
    return r;
  endfunction

  // Line level k cycles after the accept edge: bit slot 0 start, 1..16 data, 17 stop
  function automatic logic exp_level(input logic [15:0] seq, input int k, input int cpb);
    int b;
    b = (k - 1) / cpb;
    if (b == 0) return 1'b0;
    if (b <= 16) return seq[16-b];
    return 1'b1;
  endfunction

  task automatic chk_idle(input int u, input string tag);
    chk($sformatf("%s u%0d tx", tag, u), 32'(tx[u]), 32'd1);
    chk($sformatf("%s u%0d ready", tag, u), 32'(in_ready[u]), 32'd1);
    chk($sformatf("%s u%0d busy", tag, u), 32'(busy[u]), 32'd0);
    chk($sformatf("%s u%0d done", tag, u), 32'(done[u]), 32'd0);
  endtask

  // Entered at the negedge of cycle 1; leaves at the negedge of the done cycle
  task automatic check_frame(input int u, input logic [15:0] seq, input string tag,
                             output logic [15:0] rx);
    int cpb;
    cpb = cpb_u[u];
    rx = '0;
    for (int k = 1; k <= 18 * cpb; k++) begin
      chk($sformatf("%s k%0d tx", tag, k), 32'(tx[u]), 32'(exp_level(seq, k, cpb)));
      chk($sformatf("%s k%0d busy", tag, k), 32'(busy[u]), 32'd1);
      chk($sformatf("%s k%0d ready", tag, k), 32'(in_ready[u]), 32'd0);
      chk($sformatf("%s k%0d done", tag, k), 32'(done[u]), 32'd0);
      if ((k - 1) / cpb >= 1 && (k - 1) / cpb <= 16 && (k - 1) % cpb == cpb / 2) begin
        rx = lsb_u[u] ? {tx[u], rx[15:1]} : {rx[14:0], tx[u]};
      end
      @(negedge clk);
    end
    chk($sformatf("%s done-cycle done", tag), 32'(done[u]), 32'd1);
    chk($sformatf("%s done-cycle tx", tag), 32'(tx[u]), 32'd1);
    chk($sformatf("%s done-cycle ready", tag), 32'(in_ready[u]), 32'd1);
    chk($sformatf("%s done-cycle busy", tag), 32'(busy[u]), 32'd0);
  endtask

  // Called at a negedge with the unit idle
  task automatic send(input int u, input logic [15:0] w, input string tag);
    logic [15:0] rx;
    chk($sformatf("%s ready before send", tag), 32'(in_ready[u]), 32'd1);
    in_data[u]  = w;
    in_valid[u] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[u] = 1'b0;
    in_data[u]  = 16'($urandom);
    check_frame(u, tx_order(w, lsb_u[u]), tag, rx);
    chk($sformatf("%s loopback", tag), 32'(rx), 32'(w));
  endtask

  typedef struct {
    int          unit;
    logic [15:0] word;
    logic [15:0] seq;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [6];
    logic [15:0] rx;
    logic [15:0] w;

    tbl[0] = '{0, 16'hA5C3, 16'hC3A5};
    tbl[1] = '{1, 16'h8001, 16'h8001};
    tbl[2] = '{2, 16'hA5C3, 16'hC3A5};
    tbl[3] = '{0, 16'h00FF, 16'hFF00};
    tbl[4] = '{0, 16'h1234, 16'h2C48};
    tbl[5] = '{1, 16'h1234, 16'h1234};

    for (int u = 0; u < 3; u++) begin
      in_valid[u] = 1'b0;
      in_data[u]  = '0;
    end

    // Reset and idle
    repeat (3) @(negedge clk);
    for (int u = 0; u < 3; u++) chk_idle(u, "in reset");
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int u = 0; u < 3; u++) chk_idle(u, $sformatf("idle c%0d", c));
    end

    // Table of known frames, hand-derived bit orders
    for (int i = 0; i < 6; i++) begin
      int u;
      u = tbl[i].unit;
      in_data[u]  = tbl[i].word;
      in_valid[u] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid[u] = 1'b0;
      in_data[u]  = ~tbl[i].word;
      check_frame(u, tbl[i].seq, $sformatf("vec%0d", i), rx);
      chk($sformatf("vec%0d loopback", i), 32'(rx), 32'(tbl[i].word));
      @(negedge clk);
      chk($sformatf("vec%0d done after", i), 32'(done[u]), 32'd0);
    end

    // Back-to-back with in_valid held: second word taken only in the done cycle
    in_data[0]  = 16'h1234;
    in_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_data[0] = 16'hFFFF;
    check_frame(0, 16'h2C48, "b2b first", rx);
    chk("b2b first loopback", 32'(rx), 32'h1234);
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    in_data[0]  = 16'h0000;
    check_frame(0, 16'hFFFF, "b2b second", rx);
    chk("b2b second loopback", 32'(rx), 32'hFFFF);
    @(negedge clk);
    chk("b2b done after", 32'(done[0]), 32'd0);
    chk("b2b idle after", 32'(busy[0]), 32'd0);

    // Reset at cycle 30 of a frame, then a clean send
    in_data[0]  = 16'hBEEF;
    in_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (29) @(negedge clk);
    chk("mid-frame busy before reset", 32'(busy[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("reset tx immediate", 32'(tx[0]), 32'd1);
    chk("reset busy immediate", 32'(busy[0]), 32'd0);
    chk("reset ready immediate", 32'(in_ready[0]), 32'd1);
    @(negedge clk);
    chk("reset done", 32'(done[0]), 32'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_idle(0, $sformatf("post-reset c%0d", c));
    end
    send(0, 16'h00FF, "after reset");

    // Random words against the model, with random idle gaps
    for (int n = 0; n < 100; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      w = 16'($urandom);
      send(0, w, $sformatf("rnd cpb4 n%0d", n));
    end
    for (int n = 0; n < 100; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      w = 16'($urandom);
      send(2, w, $sformatf("rnd cpb1 n%0d", n));
    end
    for (int n = 0; n < 20; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      w = 16'($urandom);
      send(1, w, $sformatf("rnd msb n%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
